// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-ported unified memory between an instruction
// fetch port and a load/store port, with one transaction in flight at a time.
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state, w_nextState;
  logic [CW-1:0]   r_cnt, w_nextCnt;
  logic            r_ownerData;
  logic            r_opWe;
  // Reset value (fetch won last) makes data the favoured port in the first tie.
  logic            r_lastWinnerData;
  logic            w_grantIf, w_grantD, w_done, w_contention;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_grantIf   = 1'b0;
    w_grantD    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          if (if_req && d_req) begin
            if (r_lastWinnerData) w_grantIf = 1'b1;
            else                  w_grantD  = 1'b1;
          end else begin
            w_grantIf = if_req;
            w_grantD  = d_req;
          end
        end
        if (w_grantIf || w_grantD) begin
          w_nextState = BUSY;
          w_nextCnt   = CW'(MEM_LATENCY - 1);
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_done      = ~rst;
          w_nextState = IDLE;
        end else begin
          w_nextCnt = r_cnt - CW'(1);
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_contention = if_req && d_req && (r_state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_ownerData      <= 1'b0;
      r_opWe           <= 1'b0;
      r_lastWinnerData <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_grantIf || w_grantD) begin
        r_ownerData <= w_grantD;
        r_opWe      <= w_grantD & d_we;
      end
      if (w_contention) r_lastWinnerData <= w_grantD;
    end
  end

  assign if_gnt    = w_grantIf;
  assign d_gnt     = w_grantD;
  assign mem_req   = w_grantIf | w_grantD;
  assign mem_we    = w_grantD & d_we;
  assign mem_addr  = w_grantD ? d_addr : (w_grantIf ? if_addr : '0);
  assign mem_wdata = w_grantD ? d_wdata : '0;
  assign mem_be    = w_grantD ? d_be : (w_grantIf ? 4'hF : 4'h0);

  // Read data is forced to zero outside the owner's response pulse.
  assign if_rvalid = w_done & ~r_ownerData;
  assign d_rvalid  = w_done & r_ownerData;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !r_opWe) ? mem_rdata : '0;

  assign stall = ~rst & ((if_req & ~if_gnt) | (d_req & ~d_gnt) | (r_state == BUSY));

endmodule
